tinyalu_requester: RTL and testbench

Initiator-side front end for the tinyalu start/done protocol. Accepts ALU commands on a valid/ready stream and buffers them in a small FIFO. Drives one command at a time onto the ALU start/A/B/op pins and holds start until done or timeout. Returns the result, or an error, on a valid/ready response stream. Sits between the testbench or host sequencer and the tinyalu instance.

---
 rtl/tinyalu_pkg.sv | 27 ++
 rtl/tinyalu_requester_fifo.sv | 53 +++++
 rtl/tinyalu_requester.sv | 150 +++++++++++++++
 tb/tb_tinyalu_requester.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// Shared types for the tinyalu requester: opcodes, the queued command record
// and the requester FSM states.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    NO_OP = 3'b000,
    ADD   = 3'b001,
    AND   = 3'b010,
    XOR   = 3'b011,
    MUL   = 3'b100
  } op_e;

  // op is kept as raw bits because every 1xx encoding means multiply
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    GAP  = 2'd3
  } req_state_e;

endpackage

// File: rtl/tinyalu_requester_fifo.sv
// Small synchronous command FIFO; DEPTH must be a power of two so the
// pointers wrap naturally.
module requester_fifo
  import tinyalu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     push,
  input  alu_cmd_t wr_data,
  input  logic     pop,
  output alu_cmd_t rd_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  alu_cmd_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tinyalu_requester.sv
// Initiator front end for the tinyalu start/done protocol: queues commands,
// drives one at a time onto the ALU and returns result or timeout error.
module tinyalu_requester
  import tinyalu_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic        alu_start,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_err,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  req_state_e  state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic        start_next;
  logic [7:0]  a_next, b_next;
  logic [2:0]  op_next;
  logic        rsp_valid_next;
  logic [15:0] rsp_result_next;
  logic [2:0]  rsp_op_next;
  logic        rsp_err_next;

  alu_cmd_t    head;
  logic        fifo_full, fifo_empty, pop;

  requester_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cmd_valid && cmd_ready),
    .wr_data ('{a: cmd_a, b: cmd_b, op: cmd_op}),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_start  <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      alu_start  <= start_next;
      alu_a      <= a_next;
      alu_b      <= b_next;
      alu_op     <= op_next;
      rsp_valid  <= rsp_valid_next;
      rsp_result <= rsp_result_next;
      rsp_op     <= rsp_op_next;
      rsp_err    <= rsp_err_next;
    end
  end

  // GAP already holds start low for a cycle, so it may dispatch the next
  // command itself; this gives 4-cycle add and 7-cycle mul throughput.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    start_next      = alu_start;
    a_next          = alu_a;
    b_next          = alu_b;
    op_next         = alu_op;
    rsp_valid_next  = rsp_valid;
    rsp_result_next = rsp_result;
    rsp_op_next     = rsp_op;
    rsp_err_next    = rsp_err;
    pop             = 1'b0;

    unique case (state)
      IDLE, GAP: begin
        state_next = IDLE;
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.op == NO_OP) begin
            rsp_result_next = '0;
            rsp_op_next     = NO_OP;
            rsp_err_next    = 1'b0;
            rsp_valid_next  = 1'b1;
            state_next      = RESP;
          end else begin
            a_next     = head.a;
            b_next     = head.b;
            op_next    = head.op;
            start_next = 1'b1;
            cnt_next   = '0;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (alu_done) begin
          rsp_result_next = alu_result;
          rsp_op_next     = alu_op;
          rsp_err_next    = 1'b0;
          rsp_valid_next  = 1'b1;
          start_next      = 1'b0;
          state_next      = RESP;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          rsp_result_next = '0;
          rsp_op_next     = alu_op;
          rsp_err_next    = 1'b1;
          rsp_valid_next  = 1'b1;
          start_next      = 1'b0;
          state_next      = RESP;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = GAP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tinyalu_requester.sv
// Directed bench for tinyalu_requester with a behavioural tinyalu model
// (1-cycle done for add/and/xor, 4-cycle done for mul).
module tb_tinyalu_requester;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [2:0]  cmd_op = '0;
  logic        alu_start;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic        model_done;
  logic [15:0] model_result;
  int          model_cnt;
  logic        hang = 1'b0;
  logic        stray_done = 1'b0;

  always #5 clk = ~clk;

  tinyalu_requester #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_start  (alu_start),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  function automatic int aluLatency(input logic [2:0] op);
    return op[2] ? 4 : 1;
  endfunction

  function automatic logic [15:0] aluCalc(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
    if (op[2]) return 16'(a) * 16'(b);
    case (op)
      3'b001:  return 16'(a) + 16'(b);
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_done   = model_done | stray_done;
  assign alu_result = model_result;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_done   <= 1'b0;
      model_cnt    <= 0;
      model_result <= '0;
    end else if (alu_start && !model_done && !hang) begin
      model_cnt <= model_cnt + 1;
      if (model_cnt + 1 == aluLatency(alu_op)) begin
        model_done   <= 1'b1;
        model_result <= aluCalc(alu_a, alu_b, alu_op);
      end
    end else begin
      model_done <= 1'b0;
      model_cnt  <= 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the accepting edge (E0).
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] op);
    int n;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (!cmd_ready) checkOutput("cmd_accept_timeout", 32'd0, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic runCmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, input int exp_tick, input int exp_starts,
                        input logic [15:0] exp_result, input logic exp_err);
    int first;
    int starts;
    rsp_ready = 1'b0;
    applyStimulus(a, b, op);
    first = 0;
    starts = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (alu_start) starts++;
      if (rsp_valid) begin
        first = t;
        break;
      end
    end
    checkOutput({tag, "_latency"}, 32'(first), 32'(exp_tick));
    checkOutput({tag, "_start_cycles"}, 32'(starts), 32'(exp_starts));
    checkOutput({tag, "_result"}, 32'(rsp_result), 32'(exp_result));
    checkOutput({tag, "_op"}, 32'(rsp_op), 32'(op));
    checkOutput({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    rsp_ready = 1'b1;
    tick();
    checkOutput({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;
    tick();
  endtask

  logic [15:0] exp_res [5] = '{16'h0030, 16'h00FF, 16'h0100, 16'h0000, 16'h000F};
  logic [2:0]  exp_ops [5] = '{3'b010, 3'b011, 3'b001, 3'b000, 3'b100};
  int          exp_gap [4] = '{4, 4, 2, 7};

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    int last_t;
    int bad;
    int n;
    logic [15:0] hold_res;
    logic [2:0]  hold_op;
    logic        hold_err;

    // Reset state
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_alu_start", 32'(alu_start), 32'd0);
    checkOutput("reset_alu_abop", {13'd0, alu_a, alu_b, alu_op}, 32'd0);
    checkOutput("reset_rsp", {12'd0, rsp_valid, rsp_result, rsp_op}, 32'd0);
    checkOutput("reset_err_busy", {30'd0, rsp_err, busy}, 32'd0);

    // Single commands
    runCmd("add", 8'h12, 8'h34, 3'b001, 3, 2, 16'h0046, 1'b0);
    checkOutput("gap_busy", 32'(busy), 32'd0);
    runCmd("mul", 8'hFF, 8'hFF, 3'b100, 6, 5, 16'hFE01, 1'b0);
    runCmd("noop", 8'h77, 8'h88, 3'b000, 1, 0, 16'h0000, 1'b0);

    // Fill the FIFO while the response side is stalled
    rsp_ready = 1'b0;
    applyStimulus(8'hF0, 8'h3C, 3'b010);
    applyStimulus(8'hAA, 8'h55, 3'b011);
    applyStimulus(8'h80, 8'h80, 3'b001);
    applyStimulus(8'h11, 8'h22, 3'b000);
    applyStimulus(8'h03, 8'h05, 3'b100);
    checkOutput("fill_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("fill_busy", 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    idx = 0;
    last_t = 0;
    for (int t = 0; t < 200 && idx < 5; t++) begin
      if (rsp_valid) begin
        checkOutput($sformatf("fill_result%0d", idx), 32'(rsp_result), 32'(exp_res[idx]));
        checkOutput($sformatf("fill_op%0d", idx), 32'(rsp_op), 32'(exp_ops[idx]));
        if (idx > 0)
          checkOutput($sformatf("fill_spacing%0d", idx), 32'(t - last_t), 32'(exp_gap[idx-1]));
        last_t = t;
        idx++;
      end
      tick();
    end
    checkOutput("fill_count", 32'(idx), 32'd5);
    rsp_ready = 1'b0;
    tick();

    // Timeout, then normal recovery
    hang = 1'b1;
    runCmd("timeout", 8'h0F, 8'hF0, 3'b011, 17, 16, 16'h0000, 1'b1);
    hang = 1'b0;
    runCmd("recover", 8'h01, 8'h02, 3'b001, 3, 2, 16'h0003, 1'b0);

    // Reset in the middle of a mul with another command queued
    applyStimulus(8'h07, 8'h09, 3'b100);
    applyStimulus(8'h01, 8'h01, 3'b001);
    tick();
    checkOutput("prereset_start", 32'(alu_start), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midreset_start", 32'(alu_start), 32'd0);
    checkOutput("midreset_valid", 32'(rsp_valid), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    bad = 0;
    repeat (4) begin
      tick();
      if (rsp_valid || busy || alu_start) bad++;
    end
    checkOutput("stray_done_ignored", 32'(bad), 32'd0);

    // Stalled response stays stable; one GAP cycle before next start
    rsp_ready = 1'b0;
    applyStimulus(8'h21, 8'h43, 3'b001);
    applyStimulus(8'h05, 8'h06, 3'b001);
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
    checkOutput("hold_result", 32'(rsp_result), 32'h0064);
    hold_res = rsp_result;
    hold_op = rsp_op;
    hold_err = rsp_err;
    bad = 0;
    repeat (10) begin
      tick();
      if (!rsp_valid || rsp_result !== hold_res || rsp_op !== hold_op ||
          rsp_err !== hold_err || alu_start) bad++;
    end
    checkOutput("hold_stable", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("gap_start_low", 32'(alu_start), 32'd0);
    checkOutput("gap_valid_low", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("gap_next_start", 32'(alu_start), 32'd1);
    checkOutput("gap_next_operands", {13'd0, alu_a, alu_b, alu_op}, {13'd0, 8'h05, 8'h06, 3'b001});
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("gap_next_result", 32'(rsp_result), 32'h000B);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
